// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter among NUM_REQ byte producers. It arbitrates the
// requests round robin, loads the winning byte with a one-cycle write strobe,
// generates the bit-rate tick and watches the transmitter busy flag.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid         per-requester byte valid
//   i_req_data          byte for requester i at [8i+7:8i]
//   o_req_ready         accept strobe (IDLE only, at most one bit high)
//   o_tx_wr_enb         one-cycle write strobe to the transmitter
//   o_tx_data           byte held for the transmitter
//   o_tx_enb            bit-rate tick, one cycle wide
//   i_tx_busy           transmitter busy flag
//   o_grant_id          requester owning the current frame
//   o_active            FSM not idle
//   o_tx_done           one-cycle pulse at frame completion
//   o_err_timeout       sticky: transmitter never raised busy
//   i_err_clr           clears o_err_timeout
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [8*NUM_REQ-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_tx_wr_enb,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_enb,
    input  logic                       i_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_active,
    output logic                       o_tx_done,
    output logic                       o_err_timeout,
    input  logic                       i_err_clr
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [7:0]      r_tx_data;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last_grant;
    logic [BW-1:0]   r_baud;
    logic [TW-1:0]   r_timeout;
    logic            r_err;

    logic            w_found;
    logic [GW-1:0]   w_win;
    logic [GW-1:0]   w_idx;
    logic [7:0]      w_sel_data;
    logic            w_accept;
    logic            w_to_hit;
    logic            w_baud_wrap;

    // Round-robin search upward from the requester after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Byte lane of the winning requester.
    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == GW'(i)) begin
                w_sel_data = i_req_data[8*i +: 8];
            end
        end
    end

    // Reset has precedence over an accept in the same cycle.
    assign w_accept    = (r_state == S_IDLE) && w_found && !i_rst;
    assign w_to_hit    = (r_state == S_WAIT_BUSY) && !i_tx_busy &&
                         (r_timeout >= TW'(BUSY_TIMEOUT - 1));
    assign w_baud_wrap = (r_baud == BW'(CLKS_PER_BIT - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_next_state = S_WAIT_DONE;
                end else if (w_to_hit) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        o_req_ready = '0;
        if (w_accept) begin
            o_req_ready[w_win] = 1'b1;
        end
        o_tx_wr_enb = (r_state == S_ISSUE);
        o_active    = (r_state != S_IDLE);
        o_tx_done   = (r_state == S_WAIT_DONE) && !i_tx_busy;
        // Tick masked while the baud counter is being re-aligned to the strobe.
        o_tx_enb    = w_baud_wrap && (r_state != S_ISSUE);
    end

    assign o_tx_data     = r_tx_data;
    assign o_grant_id    = r_grant;
    assign o_err_timeout = r_err;

    // Datapath: frame byte, grant history, baud and timeout counters, error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_data    <= '0;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_baud       <= '0;
            r_timeout    <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tx_data <= w_sel_data;
                r_grant   <= w_win;
            end

            if (o_tx_done || w_to_hit) begin
                r_last_grant <= r_grant;
            end

            if ((r_state == S_ISSUE) || w_baud_wrap) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end

            // Saturating wait counter, re-armed at every strobe.
            if (r_state == S_ISSUE) begin
                r_timeout <= '0;
            end else if ((r_state == S_WAIT_BUSY) && !i_tx_busy &&
                         (r_timeout != TW'(BUSY_TIMEOUT))) begin
                r_timeout <= r_timeout + TW'(1);
            end

            // A new timeout wins over a simultaneous clear.
            if (w_to_hit) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
